module_seg_capture: RTL
=======================

Name: module_seg_capture

Overview:
- Reverse direction of the 7-segment display decode path: observes a multiplexed 7-segment bus (segment lines plus per-digit anode strobes) and recovers the digit value shown on each position.
- Used as an in-system display monitor and as the checker end of the display datapath.
- Each digit's pattern must be stable for a programmable number of cycles before it is captured, decoded back to a 4-bit code, and stored.
- Raises a frame strobe once every digit has been captured, and flags illegal segment patterns.

Parameters:
- N_DIGITS, 4, number of multiplexed digit positions (anode lines).
- STABLE_CYC, 4, consecutive identical samples required before capture; legal range 2..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_i  input  7  segment lines, bit6=A … bit0=G, active-high (1 = lit).
- an_i  input  N_DIGITS  digit select, active-high, one-hot when valid; bit0 = digit 0.
- clear_i  input  1  synchronous clear of all captured state.
- digits_o  output  4*N_DIGITS  captured codes, nibble k = digit k.
- dig_valid_o  output  N_DIGITS  bit k = nibble k holds a legal capture.
- frame_o  output  1  one-cycle pulse when every digit has been captured since the last frame.
- err_o  output  1  sticky, set on any illegal pattern capture.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: digits_o=0, dig_valid_o=0, frame_o=0, err_o=0, internal frame mask=0, FSM=IDLE, counter=0. Applies immediately, including mid-TRACK.
- Input stage: seg_i and an_i are registered once (s_seg, s_an). All decisions use the registered samples.
- "Change": s_seg or s_an differs from the previous registered sample.
- FSM states:
  - IDLE:
    - s_an not one-hot: stay.
    - s_an one-hot: go TRACK, cnt=1.
  - TRACK:
    - On change with new s_an one-hot: cnt=1, stay TRACK.
    - On change with s_an not one-hot: go IDLE.
    - No change: cnt+1.
    - When cnt reaches STABLE_CYC: capture into digit k (index of the set s_an bit), go HOLD.
  - HOLD:
    - No change: stay; no re-capture.
    - On change: same rules as a change in TRACK.
- Latency: a pattern stable on the input across edges t0..t0+STABLE_CYC is visible on digits_o/dig_valid_o after edge t0+STABLE_CYC. A shorter run never captures.
- Decode (exact match only):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000 (blank) → 4'hA, treated as legal.
  - Any other pattern is illegal: nibble k=4'hF, dig_valid_o[k]=0, err_o=1 (sticky).
- Legal capture: nibble k updated, dig_valid_o[k]=1, frame mask bit k set.
- Illegal capture: frame mask bit k still set.
- Frame: if a capture makes the frame mask all-ones, then on the same edge the mask is cleared and frame_o=1 for exactly one cycle. Re-capturing an already-masked digit does not pulse.
- clear_i: at the next edge, clears digits_o, dig_valid_o, err_o and mask, forces frame_o=0 and FSM=IDLE. clear_i beats a simultaneous capture; the capture is discarded.
- Overflow: cnt saturates at STABLE_CYC and does not wrap. Counter width = $clog2(STABLE_CYC+1).
- an_i with zero or multiple bits set never captures.

Test Plan:
- Reset: assert rst mid-TRACK (an_i=0001, seg_i=0110000, 2 cycles) → all outputs 0 immediately; after release plus STABLE_CYC+1 cycles of held input, digits_o[3:0]=1.
- Latency: an_i=0001, seg_i=1101101 held → dig_valid_o=0001 and digits_o[3:0]=2 exactly after edge t0+4, still 0 after edge t0+3.
- Glitch: same as above, but seg_i flips to 1111001 for one cycle at cycle 2, then returns → no capture until 4 new stable samples; digits_o[3:0]=2.
- Full scan: digits 0..3 shown as 1,2,3,4, 6 cycles each → digits_o=16'h4321, dig_valid_o=1111, frame_o single pulse on the 4th capture; second identical scan gives exactly one more pulse.
- Error and blank: digit 2 shows 1000000 → nibble2=F, dig_valid_o[2]=0, err_o=1 and stays 1 over a subsequent legal scan; digit 1 blank → nibble1=A. clear_i → all zero.
- Illegal select: an_i=0011 or 0000 held 10 cycles with seg_i=1111111 → no output change, no frame_o.

Source files
------------

// File: rtl/module_seg_capture.sv
// Multiplexed 7-segment bus monitor: debounces each strobed digit, decodes the
// segment pattern back to a 4-bit code and raises a frame pulse per full scan.
module module_seg_capture #(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_i,
    input  logic [N_DIGITS-1:0]   an_i,
    input  logic                  clear_i,
    output logic [4*N_DIGITS-1:0] digits_o,
    output logic [N_DIGITS-1:0]   dig_valid_o,
    output logic                  frame_o,
    output logic                  err_o
);

    localparam int              CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYC);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic [6:0]          r_s_seg, r_p_seg;
    logic [N_DIGITS-1:0] r_s_an, r_p_an;
    logic [N_DIGITS-1:0] r_mask;
    logic [CW-1:0]       r_cnt;
    state_t              r_state;

    logic                w_change;
    logic                w_onehot;
    logic                w_capture;
    logic [3:0]          w_code;
    logic                w_legal;
    logic [N_DIGITS-1:0] w_mask_nxt;

    // Exact-match decode; anything unrecognised maps to 4'hF and is flagged.
    always_comb begin
        w_legal = 1'b1;
        case (r_s_seg)
            7'b1111110: w_code = 4'h0;
            7'b0110000: w_code = 4'h1;
            7'b1101101: w_code = 4'h2;
            7'b1111001: w_code = 4'h3;
            7'b0110011: w_code = 4'h4;
            7'b1011011: w_code = 4'h5;
            7'b1011111: w_code = 4'h6;
            7'b1110000: w_code = 4'h7;
            7'b1111111: w_code = 4'h8;
            7'b1111011: w_code = 4'h9;
            7'b0000000: w_code = 4'hA;
            default: begin
                w_code  = 4'hF;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_change   = (r_s_seg != r_p_seg) || (r_s_an != r_p_an);
    assign w_onehot   = (r_s_an != '0) && ((r_s_an & (r_s_an - N_DIGITS'(1))) == '0);
    // The edge that would take the counter to STABLE_CYC is the capture edge.
    assign w_capture  = (r_state == TRACK) && !w_change && (r_cnt == CNT_MAX - CNT_ONE);
    assign w_mask_nxt = r_mask | r_s_an;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_seg     <= '0;
            r_s_an      <= '0;
            r_p_seg     <= '0;
            r_p_an      <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_state     <= IDLE;
            digits_o    <= '0;
            dig_valid_o <= '0;
            frame_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            r_s_seg <= seg_i;
            r_s_an  <= an_i;
            r_p_seg <= r_s_seg;
            r_p_an  <= r_s_an;
            frame_o <= 1'b0;
            if (clear_i) begin
                r_mask      <= '0;
                r_cnt       <= '0;
                r_state     <= IDLE;
                digits_o    <= '0;
                dig_valid_o <= '0;
                err_o       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_onehot) begin
                            r_state <= TRACK;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    TRACK, HOLD: begin
                        if (w_change) begin
                            if (w_onehot) begin
                                r_state <= TRACK;
                                r_cnt   <= CNT_ONE;
                            end else begin
                                r_state <= IDLE;
                                r_cnt   <= '0;
                            end
                        end else if (r_state == TRACK) begin
                            if (r_cnt != CNT_MAX)
                                r_cnt <= r_cnt + CNT_ONE;
                            if (w_capture) begin
                                r_state <= HOLD;
                                for (int k = 0; k < N_DIGITS; k++) begin
                                    if (r_s_an[k]) begin
                                        digits_o[4*k +: 4] <= w_code;
                                        dig_valid_o[k]     <= w_legal;
                                    end
                                end
                                if (!w_legal)
                                    err_o <= 1'b1;
                                if (&w_mask_nxt) begin
                                    r_mask  <= '0;
                                    frame_o <= 1'b1;
                                end else begin
                                    r_mask  <= w_mask_nxt;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
